// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA tile scheduler and its address generator.
package dma_pkg;

    localparam int DMA_ADDR_W      = 32;
    localparam int DMA_TAG_W       = 8;
    localparam int DMA_BURST_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } sched_state_e;

    function automatic logic [63:0] min_len(input logic [63:0] a, input logic [63:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_tile_addr_gen.sv
// Walks a 2D tile row by row, producing burst-sized address/length chunks.
// The row base is accumulated by adding the stride once per row, so no multiplier is needed.
module dma_tile_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_W      = DMA_ADDR_W,
    parameter int BURST_BYTES = DMA_BURST_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [15:0]       rows_i,
    input  logic [ADDR_W-1:0] row_bytes_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] len_o,
    output logic              last_o
);

    localparam logic [63:0] BURST_LEN = 64'(BURST_BYTES);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [15:0]       row_q, row_d;
    logic [15:0]       rows_q, rows_d;
    logic [ADDR_W-1:0] row_bytes_q, row_bytes_d;
    logic [ADDR_W-1:0] stride_q, stride_d;

    logic [ADDR_W-1:0] remaining;
    logic              row_end;

    always_comb begin
        remaining = row_bytes_q - col_q;
        len_o     = ADDR_W'(min_len(BURST_LEN, 64'(remaining)));
        row_end   = (len_o == remaining);
        last_o    = row_end && (row_q == rows_q - 16'd1);
        addr_o    = row_base_q + col_q;
    end

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        row_base_d  = row_base_q;
        col_d       = col_q;
        row_d       = row_q;
        rows_d      = rows_q;
        row_bytes_d = row_bytes_q;
        stride_d    = stride_q;
        if (load_i) begin
            row_base_d  = base_i;
            col_d       = '0;
            row_d       = '0;
            rows_d      = rows_i;
            row_bytes_d = row_bytes_i;
            stride_d    = stride_i;
        end else if (advance_i) begin
            if (row_end) begin
                col_d      = '0;
                row_d      = row_q + 16'd1;
                row_base_d = row_base_q + stride_q;
            end else begin
                col_d = col_q + len_o;
            end
        end
    end

    // NOTE: the captured job fields are reset too; they are few flops, not a memory,
    // and resetting them keeps X off the address/length path after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rows_q      <= '0;
            row_bytes_q <= '0;
            stride_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            row_bytes_q <= row_bytes_d;
            stride_q    <= stride_d;
        end
    end

endmodule

// File: rtl/dma_tile_scheduler.sv
// Splits one 2D tile-fetch job into burst requests for dma_engine and counts completions.
// Optional DMA_SCHED_PERF_EN builds job-cycle and stall-cycle performance counters.
module dma_tile_scheduler
    import dma_pkg::*;
#(
    parameter int BURST_BYTES = DMA_BURST_BYTES,
    parameter int ADDR_W      = DMA_ADDR_W,
    parameter int TAG_W       = DMA_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_base_addr,
    input  logic [15:0]       job_rows,
    input  logic [ADDR_W-1:0] job_row_bytes,
    input  logic [ADDR_W-1:0] job_stride,
    output logic              job_done,
    output logic              busy,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [ADDR_W-1:0] issue_base_addr,
    output logic [ADDR_W-1:0] issue_length,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic              done_valid,
    input  logic [TAG_W-1:0]  done_tag,
    output logic [ADDR_W-1:0] reqs_issued,
    output logic [ADDR_W-1:0] perf_job_cycles,
    output logic [ADDR_W-1:0] perf_stall_cycles
);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] reqs_issued_q, reqs_issued_d;
    logic [ADDR_W-1:0] done_cnt_q, done_cnt_d;

    logic              job_accept;
    logic              issue_fire;
    logic              done_count;
    logic [ADDR_W-1:0] gen_addr;
    logic [ADDR_W-1:0] gen_len;
    logic              gen_last;

    logic unused_tags;
    assign unused_tags = ^{issue_tag, done_tag};

    assign job_ready   = (state_q == IDLE);
    assign issue_valid = (state_q == ISSUE);
    assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign job_done    = (state_q == FIN);
    assign reqs_issued = reqs_issued_q;

    // Zeroed outside ISSUE so idle outputs match their reset values.
    assign issue_base_addr = issue_valid ? gen_addr : '0;
    assign issue_length    = issue_valid ? gen_len  : '0;

    assign job_accept = job_valid && job_ready;
    assign issue_fire = issue_valid && issue_ready;
    assign done_count = done_valid && busy;

    dma_tile_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_BYTES (BURST_BYTES)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (job_accept),
        .advance_i   (issue_fire),
        .base_i      (job_base_addr),
        .rows_i      (job_rows),
        .row_bytes_i (job_row_bytes),
        .stride_i    (job_stride),
        .addr_o      (gen_addr),
        .len_o       (gen_len),
        .last_o      (gen_last)
    );

    always_comb begin
        state_d       = state_q;
        reqs_issued_d = reqs_issued_q;
        done_cnt_d    = done_cnt_q;

        if (job_accept) begin
            reqs_issued_d = '0;
            done_cnt_d    = '0;
        end else begin
            if (issue_fire) reqs_issued_d = reqs_issued_q + ADDR_W'(1);
            if (done_count) done_cnt_d    = done_cnt_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (job_accept) begin
                    if (job_rows == 16'd0 || job_row_bytes == '0) state_d = FIN;
                    else                                          state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_fire && gen_last) state_d = DRAIN;
            end
            // Uses the post-update count so a done in this cycle finishes the job next cycle.
            DRAIN: begin
                if (done_cnt_d == reqs_issued_q) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            reqs_issued_q <= '0;
            done_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            reqs_issued_q <= reqs_issued_d;
            done_cnt_q    <= done_cnt_d;
        end
    end

`ifdef DMA_SCHED_PERF_EN
    logic [ADDR_W-1:0] perf_job_q;
    logic [ADDR_W-1:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_job_q   <= '0;
            perf_stall_q <= '0;
        end else if (job_accept) begin
            perf_job_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy)                       perf_job_q   <= perf_job_q + ADDR_W'(1);
            if (issue_valid && !issue_ready) perf_stall_q <= perf_stall_q + ADDR_W'(1);
        end
    end

    assign perf_job_cycles   = perf_job_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_job_cycles   = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule
